uart_rx_path: RTL
=================

// Module: uart_rx_path
// PURPOSE
//  Receive side of the UART; the direct downstream consumer of Tx_path's serial Tx line.
//  Detects a start bit, samples each bit at mid-bit, and deserialises WIDTH_SIZE data bits LSB first.
//  Checks the optional even-parity bit and the stop bit.
//  Presents each word plus error flags on a valid/ready interface to the consumer.
// PARAMETERS
//  WIDTH_SIZE    32  data bits per frame; must equal Tx_path WIDTH_SIZE
//  CLKS_PER_BIT  16  clk cycles per serial bit (>=4); must equal the Tx_path bit period
// PORTS
//  clk         in   1           system clock, rising edge
//  reset       in   1           asynchronous, active-high
//  Rx          in   1           serial line, idle high; asynchronous to clk
//  PF          in   1           parity enable; 1 = even-parity bit follows the data
//  rx_data     out  WIDTH_SIZE  received word, LSB = first data bit on the line
//  rx_valid    out  1           rx_data and flags are valid
//  rx_ready    in   1           consumer accepts the word when rx_valid && rx_ready
//  parity_err  out  1           parity mismatch for this word; qualified by rx_valid
//  frame_err   out  1           stop bit sampled 0 for this word; qualified by rx_valid
//  overrun     out  1           sticky: a frame completed while the word register was full
// BEHAVIOUR
//  Reset: state=IDLE; rx_data=0; rx_valid=0; parity_err=0; frame_err=0; overrun=0.
//   Synchroniser flops reset to 1. Reset mid-frame aborts the frame; no partial word is emitted.
//  Rx passes through a 2-flop synchroniser (rxs); all decisions use rxs.
//  States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//  Bit counter: clk_cnt 0..CLKS_PER_BIT-1. Mid-bit sample at clk_cnt == CLKS_PER_BIT/2-1.
//  IDLE -> START on rxs==0; clear clk_cnt and bit_idx; latch PF into pf_q for the whole frame.
//  START: mid-sample rxs==1 -> IDLE (glitch, nothing emitted). rxs==0 -> restart clk_cnt, go to DATA.
//  DATA: every CLKS_PER_BIT clks, sample into shift_q[bit_idx].
//   After bit WIDTH_SIZE-1: go to PARITY if pf_q, else STOP.
//  PARITY: sample p. par_bad = p ^ (^shift_q); even parity => p == XOR of data bits.
//  STOP: sample rxs. fr_bad = ~rxs.
//   In the same cycle, load the output register (see below).
//   Then go to IDLE if rxs==1, else WAIT_HIGH.
//  WAIT_HIGH: stay until rxs==1, then IDLE. A held-low line cannot re-trigger a start.
//  Output register (1 entry):
//   Load = stop sample AND (!rx_valid OR rx_ready). Sets rx_valid=1 next cycle.
//   Loads rx_data=shift_q, parity_err=par_bad (0 when pf_q=0), frame_err=fr_bad.
//   Latency: rx_valid rises 1 clk after the stop-bit mid-sample.
//   Accept: rx_valid && rx_ready with no new load -> rx_valid=0 next clk.
//   Accept and load in the same cycle -> new word replaces the old one; rx_valid stays 1.
//   Stop sample while rx_valid && !rx_ready: the new word is dropped, the old word is kept, overrun<=1.
//   overrun clears only on reset.
//  rx_data/flags are held stable while rx_valid && !rx_ready.
//  Frames with errors are still delivered; the consumer decides whether to discard them.
//  PF changes mid-frame have no effect until the next start bit.
// STRUCTURE
//  uart_pkg (shared with Tx_path):
//   rx_state_t enum; DEFAULT_WIDTH; DEFAULT_CLKS_PER_BIT;
//   function even_parity(logic [WIDTH_SIZE-1:0]) returning ^data.
//  Sub-module uart_rx_sync: 2-flop synchroniser, async reset to 1.
//   Everything else (FSM, counters, shift register, output register) lives in uart_rx_path.
// TESTING (WIDTH_SIZE=32, CLKS_PER_BIT=16, Tx_path instance driving Rx, rx_ready=1 unless stated)
//  1 PF=0, send 0x55555555 -> one rx_valid pulse; rx_data=0x55555555; parity_err=0; frame_err=0.
//  2 PF=1, send 0x5555575D, correct parity then Tx_path err=1 (parity inverted) ->
//    first word parity_err=0; second word parity_err=1; rx_data=0x5555575D both times.
//  3 Rx low for 4 clks then high -> no rx_valid, FSM back in IDLE.
//    Then a stop bit forced 0 and the line held low 5 bit-times -> one word with frame_err=1, no second start.
//  4 rx_ready=0, send 0x11111111 then 0x22222222 -> rx_data stays 0x11111111; overrun=1.
//    Then rx_ready=1 -> 0x11111111 accepted; rx_valid=0.
//  5 Assert reset mid-DATA of 0xA5A5A5A5 -> all outputs 0 asynchronously.
//    Next frame 0x0F0F0F0F is received correctly.
//  6 Back-to-back frames with rx_ready pulsed on the load cycle -> no word lost, no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Types, defaults and helpers shared by the UART receive and transmit paths.
package uart_pkg;

  localparam int DEFAULT_WIDTH        = 32;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  // Widest word even_parity() accepts; narrower words are zero-extended by the caller.
  localparam int MAX_WIDTH            = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_path.sv
// UART receiver: start detect, mid-bit sampling, LSB-first deserialise, optional even parity,
// stop check, and a one-entry valid/ready output register with a sticky overrun flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on rxs
// START     | counting to mid start bit; high there means a glitch
// DATA      | sampling WIDTH_SIZE data bits, one per bit period
// PARITY    | sampling the even-parity bit (only when pf_q)
// STOP      | sampling the stop bit and loading the output register
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx_path
  import uart_pkg::*;
#(
  parameter int WIDTH_SIZE   = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Rx,
  input  logic                  PF,
  output logic [WIDTH_SIZE-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH_SIZE + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH_SIZE - 1);

  rx_state_t             state;
  logic                  rxs;
  logic [CW-1:0]         clk_cnt;
  logic [IW-1:0]         bit_idx;
  logic [WIDTH_SIZE-1:0] shift_q;
  logic [MAX_WIDTH-1:0]  shift_ext;
  logic                  pf_q;
  logic                  par_bad;
  logic                  bit_tick;
  logic                  stop_smp;
  logic                  load;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (Rx),
    .q     (rxs)
  );

  assign shift_ext = MAX_WIDTH'(shift_q);
  assign bit_tick  = (clk_cnt == FULL_M1);
  assign stop_smp  = (state == STOP) && bit_tick;
  assign load      = stop_smp && (!rx_valid || rx_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      pf_q       <= 1'b0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready && !load) rx_valid <= 1'b0;

      // A word arriving while the consumer still holds the previous one is dropped.
      if (load) begin
        rx_valid   <= 1'b1;
        rx_data    <= shift_q;
        parity_err <= par_bad;
        frame_err  <= ~rxs;
      end else if (stop_smp) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= '0;
            bit_idx <= '0;
            pf_q    <= PF;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            shift_q <= {rxs, shift_q[WIDTH_SIZE-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= pf_q ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            par_bad <= rxs ^ even_parity(shift_ext);
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            state   <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
